fll_loop_ctrl: RTL and testbench
================================

# fll_loop_ctrl

Digital loop controller of the frequency-locked loop. It consumes one VCO frequency measurement per reference window: a count, a valid strobe and the configured `upper`/`lower` window. It steps the 10-bit DAC word and 3-bit corner select that drive the VCO, and reports lock. It sits directly downstream of the frequency counter and upstream of the DAC/corner muxes. Its window, test-override and lock-depth inputs come from the configuration shift register.

## Interface
- `N`, 10: DAC word and count width.
- `CW`, 3: corner select width.
- `LOCK_CNT`, 4: consecutive in-window samples required for lock (1..15).
- `clk` input 1: loop clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high.
- `count` input N: VCO edges counted in last reference window.
- `count_valid` input 1: one-cycle strobe, `count` valid in same cycle.
- `upper` input N: window upper bound, inclusive.
- `lower` input N: window lower bound, inclusive.
- `test` input 1: override enable.
- `test_val` input N: DAC value forced while `test`=1.
- `dac` output N: VCO DAC word.
- `corner` output CW: VCO corner select.
- `lock` output 1: loop locked.
- `sat` output 1: DAC and corner both at an end stop and still pushed further.

## Operation
- Reset values:
  - `dac` = 2^(N-1) (512).
  - `corner` = 2^(CW-1) (4).
  - `lock`=0, `sat`=0, streak counter 0.
  - FSM = ACQ.
- FSM states: ACQ, LOCKED, SETTLE, TEST.
- Sample classification on `count_valid` (unsigned compares):
  - `count` < `lower` → UP. This has priority, so a misconfigured `lower` > `upper` never yields IN.
  - Otherwise `count` > `upper` → DOWN.
  - Otherwise → IN.
- UP:
  - `dac` < 2^N-1: `dac`+1.
  - `dac` = 2^N-1 and `corner` < 2^CW-1: `corner`+1, `dac` ← 2^(N-1), go to SETTLE.
  - Both at max: hold both, `sat`=1.
- DOWN: mirror of UP.
  - `dac` > 0: `dac`−1.
  - `dac` = 0 and `corner` > 0: `corner`−1, `dac` ← 2^(N-1), go to SETTLE.
  - Both at 0: hold both, `sat`=1.
- `sat` clears on the next IN sample, or on any UP/DOWN that moves `dac` or `corner`.
- IN: hold `dac`/`corner`; streak+1, saturating at `LOCK_CNT`.
  - ACQ → LOCKED when the streak reaches `LOCK_CNT`.
  - `lock`=1 in LOCKED.
- UP/DOWN in LOCKED:
  - streak ← 0, `lock` ← 0, go to ACQ.
  - The DAC step is still applied in that same update.
- SETTLE:
  - The next `count_valid` is discarded, since it was measured across a corner switch.
  - The streak stays 0; then go to ACQ.
- TEST: entered from any state while `test`=1.
  - `dac` ← `test_val` every cycle; `corner` held.
  - `lock`=0, streak 0, `count_valid` ignored.
  - When `test` falls, go to ACQ with `dac` keeping the last `test_val`.
- `test` has priority over `count_valid` in the same cycle.

## Timing
- All outputs are registered. `dac`/`corner`/`lock`/`sat` update on the edge after the cycle where `count_valid`=1.
- Latency is 1 cycle, with at most one step per strobe.
- `count_valid` is accepted every cycle, including back-to-back strobes.
- `upper`/`lower`/`test_val` are sampled only at strobe/test cycles. Changes between strobes have no effect.
- TEST entry: `dac` = `test_val` one cycle after `test` rises.
- Asynchronous `reset` mid-operation returns all outputs to reset values immediately. The first strobe after deassertion is processed normally.

## Structure
- Shared package `fll_pkg`:
  - state enum (ACQ, LOCKED, SETTLE, TEST);
  - sample-class enum (UP, DOWN, IN);
  - constants `DAC_MID`, `CORNER_MID`.
- One sub-module, `fll_window_cmp`: combinational classifier taking `count`/`lower`/`upper` and returning the class.
- Everything else is in `fll_loop_ctrl`.

## Test plan
- Reset, 5 strobes with `count`=100, `lower`=200, `upper`=220 → `dac` 512→517, `lock`=0.
- `dac` at 1023 with `corner`=4, strobe UP → `corner`=5, `dac`=512. The next strobe (any value) is ignored, and the following UP gives `dac`=513.
- 4 consecutive strobes with `count`=210 in window [200,220], `LOCK_CNT`=4 → `lock`=1 after the 4th. A subsequent `count`=230 → `lock`=0, `dac` −1.
- `corner`=0, `dac`=0, strobe DOWN → hold, `sat`=1. Then IN strobe → `sat`=0.
- `test`=1 with `test_val`=77 concurrent with `count_valid` → `dac`=77 next cycle, strobe ignored, `lock`=0. `test`→0 then UP → `dac`=78.
- Misconfigured `lower`=300, `upper`=100, `count`=200 → classified UP, `dac`+1. Assert `reset` mid-run → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fll_pkg.sv
// Shared types and constants for the FLL loop controller: FSM states,
// sample classes and the mid-scale reset values of the DAC and corner select.
package fll_pkg;

   localparam int DAC_W      = 10;
   localparam int CORNER_W   = 3;
   localparam int DAC_MID    = 1 << (DAC_W - 1);
   localparam int CORNER_MID = 1 << (CORNER_W - 1);

   typedef enum logic [1:0] {
      ST_ACQ,
      ST_LOCKED,
      ST_SETTLE,
      ST_TEST
   } state_e;

   typedef enum logic [1:0] {
      CLS_UP,
      CLS_DOWN,
      CLS_IN
   } sample_e;

endpackage

// File: rtl/fll_window_cmp.sv
// Combinational classifier: places a frequency count below, above or inside
// the inclusive [lower, upper] window.
module fll_window_cmp
   import fll_pkg::*;
#(
   parameter int N = DAC_W
) (
   input  logic [N-1:0] count,
   input  logic [N-1:0] lower,
   input  logic [N-1:0] upper,
   output sample_e      cls
);

   // Below-window wins, so an inverted window (lower > upper) never reports IN.
   always_comb begin
      cls = CLS_IN;
      if (count < lower) begin
         cls = CLS_UP;
      end else if (count > upper) begin
         cls = CLS_DOWN;
      end
   end

endmodule

// File: rtl/fll_loop_ctrl.sv
// FLL digital loop controller: steps the VCO DAC word and corner select from
// windowed frequency measurements, tracks the in-window streak and reports lock.
module fll_loop_ctrl
   import fll_pkg::*;
#(
   parameter int N        = DAC_W,
   parameter int CW       = CORNER_W,
   parameter int LOCK_CNT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  count,
   input  logic          count_valid,
   input  logic [N-1:0]  upper,
   input  logic [N-1:0]  lower,
   input  logic          test,
   input  logic [N-1:0]  test_val,
   output logic [N-1:0]  dac,
   output logic [CW-1:0] corner,
   output logic          lock,
   output logic          sat
);

   localparam int            SW       = $clog2(LOCK_CNT + 1);
   localparam logic [N-1:0]  DAC_RST  = N'(DAC_MID);
   localparam logic [N-1:0]  DAC_MAX  = '1;
   localparam logic [CW-1:0] COR_RST  = CW'(CORNER_MID);
   localparam logic [CW-1:0] COR_MAX  = '1;
   localparam logic [SW-1:0] LOCK_MAX = SW'(LOCK_CNT);

   state_e        state_q,  state_d;
   logic [N-1:0]  dac_q,    dac_d;
   logic [CW-1:0] corner_q, corner_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          lock_q,   lock_d;
   logic          sat_q,    sat_d;
   sample_e       cls;

   fll_window_cmp #(.N(N)) u_window_cmp (
      .count (count),
      .lower (lower),
      .upper (upper),
      .cls   (cls)
   );

   always_comb begin
      // NOTE: every *_d defaults to its flop first, so no path can leave one unassigned and infer a latch.
      state_d  = state_q;
      dac_d    = dac_q;
      corner_d = corner_q;
      streak_d = streak_q;
      lock_d   = lock_q;
      sat_d    = sat_q;

      if (test) begin
         state_d  = ST_TEST;
         dac_d    = test_val;
         streak_d = '0;
         lock_d   = 1'b0;
      end else if (count_valid && state_q == ST_SETTLE) begin
         // This measurement straddled a corner switch and is untrustworthy.
         state_d  = ST_ACQ;
         streak_d = '0;
      end else if (count_valid) begin
         if (state_q == ST_TEST) begin
            state_d = ST_ACQ;
         end
         unique case (cls)
            CLS_IN: begin
               sat_d = 1'b0;
               if (streak_q != LOCK_MAX) begin
                  streak_d = streak_q + 1'b1;
               end
               if (streak_d == LOCK_MAX) begin
                  state_d = ST_LOCKED;
                  lock_d  = 1'b1;
               end
            end
            CLS_UP: begin
               streak_d = '0;
               lock_d   = 1'b0;
               state_d  = ST_ACQ;
               if (dac_q != DAC_MAX) begin
                  dac_d = dac_q + 1'b1;
                  sat_d = 1'b0;
               end else if (corner_q != COR_MAX) begin
                  corner_d = corner_q + 1'b1;
                  dac_d    = DAC_RST;
                  state_d  = ST_SETTLE;
                  sat_d    = 1'b0;
               end else begin
                  sat_d = 1'b1;
               end
            end
            default: begin
               streak_d = '0;
               lock_d   = 1'b0;
               state_d  = ST_ACQ;
               if (dac_q != '0) begin
                  dac_d = dac_q - 1'b1;
                  sat_d = 1'b0;
               end else if (corner_q != '0) begin
                  corner_d = corner_q - 1'b1;
                  dac_d    = DAC_RST;
                  state_d  = ST_SETTLE;
                  sat_d    = 1'b0;
               end else begin
                  sat_d = 1'b1;
               end
            end
         endcase
      end else if (state_q == ST_TEST) begin
         state_d = ST_ACQ;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_ACQ;
         dac_q    <= DAC_RST;
         corner_q <= COR_RST;
         streak_q <= '0;
         lock_q   <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dac_q    <= dac_d;
         corner_q <= corner_d;
         streak_q <= streak_d;
         lock_q   <= lock_d;
         sat_q    <= sat_d;
      end
   end

   assign dac    = dac_q;
   assign corner = corner_q;
   assign lock   = lock_q;
   assign sat    = sat_q;

endmodule

// File: tb/tb_fll_loop_ctrl.sv
// Self-checking bench for fll_loop_ctrl: directed scenarios plus randomized
// strobes, all compared against an integer-level reference model.
module tb_fll_loop_ctrl;

   localparam int N        = 10;
   localparam int CW       = 3;
   localparam int LOCK_CNT = 4;
   localparam int DMAX     = (1 << N) - 1;
   localparam int CMAX     = (1 << CW) - 1;
   localparam int DMID     = 1 << (N - 1);
   localparam int CMID     = 1 << (CW - 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  count, upper, lower, test_val;
   logic          count_valid, test;
   logic [N-1:0]  dac;
   logic [CW-1:0] corner;
   logic          lock, sat;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integers, lock derived from the streak depth.
   int  m_dac, m_corner, m_streak;
   bit  m_sat, m_discard;

   fll_loop_ctrl #(.N(N), .CW(CW), .LOCK_CNT(LOCK_CNT)) dut (
      .clk         (clk),
      .reset       (reset),
      .count       (count),
      .count_valid (count_valid),
      .upper       (upper),
      .lower       (lower),
      .test        (test),
      .test_val    (test_val),
      .dac         (dac),
      .corner      (corner),
      .lock        (lock),
      .sat         (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_dac = DMID; m_corner = CMID; m_streak = 0; m_sat = 0; m_discard = 0;
   endfunction

   function automatic int m_lock();
      return (m_streak >= LOCK_CNT) ? 1 : 0;
   endfunction

   function automatic void model_step(bit t, bit cv, int c, int lo, int up, int tv);
      int dir;
      if (t) begin
         m_dac = tv; m_streak = 0; m_discard = 0;
         return;
      end
      if (!cv) return;
      if (m_discard) begin
         m_discard = 0; m_streak = 0;
         return;
      end
      dir = (c < lo) ? 1 : (c > up) ? -1 : 0;
      if (dir == 0) begin
         m_sat = 0;
         if (m_streak < LOCK_CNT) m_streak++;
         return;
      end
      m_streak = 0;
      if (dir > 0 && m_dac < DMAX) begin
         m_dac++; m_sat = 0;
      end else if (dir < 0 && m_dac > 0) begin
         m_dac--; m_sat = 0;
      end else if ((dir > 0 && m_corner < CMAX) || (dir < 0 && m_corner > 0)) begin
         m_corner += dir; m_dac = DMID; m_discard = 1; m_sat = 0;
      end else begin
         m_sat = 1;
      end
   endfunction

   task automatic compare_all();
      check("dac",    int'(dac),    m_dac);
      check("corner", int'(corner), m_corner);
      check("lock",   int'(lock),   m_lock());
      check("sat",    int'(sat),    int'(m_sat));
   endtask

   // Drive one cycle, let the model take the same step, sample #1 after the edge.
   task automatic cycle(input bit t, input bit cv, input int c, input int lo,
                        input int up, input int tv);
      test = t; count_valid = cv; count = N'(c); lower = N'(lo);
      upper = N'(up); test_val = N'(tv);
      @(posedge clk);
      model_step(t, cv, c, lo, up, tv);
      #1;
      compare_all();
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("rst_dac",    int'(dac),    DMID);
      check("rst_corner", int'(corner), CMID);
      check("rst_lock",   int'(lock),   0);
      check("rst_sat",    int'(sat),    0);
      #2 reset = 1'b0;
   endtask

   initial begin
      int lo, up, c, tmp, guard;
      reset = 1'b1; test = 0; count_valid = 0; count = '0;
      lower = '0; upper = '0; test_val = '0;
      model_reset();
      #12;
      check("init_dac",    int'(dac),    DMID);
      check("init_corner", int'(corner), CMID);
      check("init_lock",   int'(lock),   0);
      check("init_sat",    int'(sat),    0);
      reset = 1'b0;

      // Five UP strobes walk dac from mid-scale.
      for (int i = 0; i < 5; i++) cycle(0, 1, 100, 200, 220, 0);
      check("up5_dac",  int'(dac),  517);
      check("up5_lock", int'(lock), 0);

      // Corner switch from dac=1023, then the discarded strobe.
      cycle(1, 0, 0, 0, 0, DMAX);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 1, 100, 200, 220, 0);
      check("cs_corner", int'(corner), 5);
      check("cs_dac",    int'(dac),    512);
      cycle(0, 1, 100, 200, 220, 0);
      check("settle_dac", int'(dac), 512);
      cycle(0, 1, 100, 200, 220, 0);
      check("post_settle_dac", int'(dac), 513);

      // Lock after LOCK_CNT in-window strobes, lose it on an out-of-window one.
      for (int i = 0; i < LOCK_CNT; i++) begin
         cycle(0, 1, 210, 200, 220, 0);
         check("lock_ramp", int'(lock), (i == LOCK_CNT - 1) ? 1 : 0);
      end
      cycle(0, 0, 0, 200, 220, 0);
      check("lock_idle", int'(lock), 1);
      cycle(0, 1, 230, 200, 220, 0);
      check("unlock", int'(lock), 0);
      check("unlock_dac", int'(dac), 512);

      // Drive DOWN until both end stops, then push once more.
      guard = 0;
      while ((m_dac != 0 || m_corner != 0) && guard < 6000) begin
         cycle(0, 1, 300, 200, 220, 0);
         guard++;
      end
      check("reach_floor", guard < 6000 ? 1 : 0, 1);
      cycle(0, 1, 300, 200, 220, 0);
      check("sat_set",    int'(sat),    1);
      check("sat_dac",    int'(dac),    0);
      check("sat_corner", int'(corner), 0);
      cycle(0, 1, 210, 200, 220, 0);
      check("sat_clr", int'(sat), 0);

      // Test override beats a concurrent strobe.
      cycle(1, 1, 100, 200, 220, 77);
      check("test_dac",  int'(dac),  77);
      check("test_lock", int'(lock), 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 1, 100, 200, 220, 0);
      check("post_test_dac", int'(dac), 78);

      // Inverted window classifies as UP.
      cycle(0, 1, 200, 300, 100, 0);
      check("inv_win_dac", int'(dac), 79);

      async_reset();

      // Randomized traffic, occasional test pulses and async resets.
      for (int i = 0; i < 4000; i++) begin
         lo = $urandom_range(0, DMAX);
         up = lo + $urandom_range(0, 24);
         if (up > DMAX) up = DMAX;
         if ($urandom_range(0, 15) == 0) begin
            tmp = lo; lo = up; up = tmp;
         end
         c = int'($urandom_range(0, 40)) - 8 + lo;
         if ($urandom_range(0, 3) == 0) c = lo + 2;
         if (c < 0) c = 0;
         if (c > DMAX) c = DMAX;
         cycle($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1, c, lo, up,
               $urandom_range(0, DMAX));
         if ($urandom_range(0, 700) == 0) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
